// File: rtl/rx_cmd_ctrl.sv
// Line-oriented command parser: pops one byte per READ/WAIT/PARSE pass and
// turns "D<1-3 digits>\n" lines into a duty update, rejecting anything else.
module rx_cmd_ctrl #(
  parameter int MAX_DUTY   = 100,
  parameter int LINE_CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  input  logic       fifo_eos,
  output logic       fifo_rd_en,
  output logic [6:0] duty_pct,
  output logic       duty_valid,
  output logic       cmd_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, PARSE} state_e;

  localparam logic [LINE_CNT_W-1:0] PEND_MAX = '1;

  state_e                state_q, state_d;
  logic [LINE_CNT_W-1:0] pend_q, pend_d;
  logic [9:0]            acc_q, acc_d;
  logic [1:0]            dcnt_q, dcnt_d;
  logic                  cmd_q, cmd_d;
  logic                  err_q, err_d;
  logic                  started_q, started_d;
  logic [6:0]            duty_q, duty_d;
  logic                  dvld_q, dvld_d;
  logic                  cerr_q, cerr_d;

  logic        in_parse, is_lf, is_cr, is_digit, is_d;
  logic [13:0] acc_ext;

  assign in_parse = (state_q == PARSE);
  assign is_lf    = (fifo_rd_data == 8'h0A);
  assign is_cr    = (fifo_rd_data == 8'h0D);
  assign is_digit = (fifo_rd_data >= 8'h30) && (fifo_rd_data <= 8'h39);
  assign is_d     = (fifo_rd_data == 8'h44) || (fifo_rd_data == 8'h64);
  assign acc_ext  = {4'd0, acc_q} * 14'd10 + {10'd0, fifo_rd_data[3:0]};

  // Pending lines: a new eos and a consumed LF in the same cycle cancel out.
  always_comb begin
    pend_d = pend_q;
    case ({fifo_eos, in_parse && is_lf})
      2'b10:   if (pend_q != PEND_MAX)       pend_d = pend_q + 1'b1;
      2'b01:   if (pend_q != '0)             pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    dcnt_d    = dcnt_q;
    cmd_d     = cmd_q;
    err_d     = err_q;
    started_d = started_q;
    duty_d    = duty_q;
    dvld_d    = 1'b0;
    cerr_d    = 1'b0;
    fifo_rd_en = 1'b0;
    case (state_q)
      IDLE: if (pend_q != '0) state_d = READ;
      READ: if (!fifo_empty) begin
        fifo_rd_en = 1'b1;
        state_d    = WAIT;
      end
      WAIT: state_d = PARSE;
      PARSE: begin
        state_d = READ;
        if (is_lf) begin
          state_d = IDLE;
          if (started_q) begin
            if (cmd_q && !err_q && dcnt_q != 2'd0 && acc_q <= 10'(MAX_DUTY)) begin
              duty_d = acc_q[6:0];
              dvld_d = 1'b1;
            end else begin
              cerr_d = 1'b1;
            end
          end
          acc_d     = '0;
          dcnt_d    = '0;
          cmd_d     = 1'b0;
          err_d     = 1'b0;
          started_d = 1'b0;
        end else if (is_cr || err_q) begin
          // CR is transparent; an errored line drains silently to its LF
        end else if (!started_q) begin
          started_d = 1'b1;
          if (is_d) cmd_d = 1'b1;
          else      err_d = 1'b1;
        end else if (is_digit && dcnt_q != 2'd3) begin
          acc_d  = acc_ext[9:0];
          dcnt_d = dcnt_q + 1'b1;
          if (acc_ext > 14'(MAX_DUTY)) err_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      acc_q     <= '0;
      dcnt_q    <= '0;
      cmd_q     <= 1'b0;
      err_q     <= 1'b0;
      started_q <= 1'b0;
      duty_q    <= '0;
      dvld_q    <= 1'b0;
      cerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      acc_q     <= acc_d;
      dcnt_q    <= dcnt_d;
      cmd_q     <= cmd_d;
      err_q     <= err_d;
      started_q <= started_d;
      duty_q    <= duty_d;
      dvld_q    <= dvld_d;
      cerr_q    <= cerr_d;
    end
  end

  assign duty_pct   = duty_q;
  assign duty_valid = dvld_q;
  assign cmd_err    = cerr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Directed bench for rx_cmd_ctrl: byte-queue FIFO model, line-level outcome
// model and a per-cycle compare process.
module tb_rx_cmd_ctrl;
  localparam int MAX_DUTY = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_eos = 1'b0;
  logic       fifo_rd_en;
  logic [6:0] duty_pct;
  logic       duty_valid, cmd_err, busy;

  int total = 0, bad = 0;
  byte unsigned fifo_q[$];
  int exp_q[$];   // expected outcomes in order: >=0 duty value, -1 error
  int rd_log[$];
  int model_duty = 0, dv_cnt = 0, er_cnt = 0, cyc = 0;

  rx_cmd_ctrl #(.MAX_DUTY(MAX_DUTY), .LINE_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_eos(fifo_eos), .fifo_rd_en(fifo_rd_en), .duty_pct(duty_pct),
    .duty_valid(duty_valid), .cmd_err(cmd_err), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Line outcome from the text: -2 empty, -1 rejected, else duty value.
  function automatic int model_line(input string s);
    byte unsigned b[$];
    int v = 0;
    for (int i = 0; i < s.len(); i++)
      if (s[i] != 8'h0D && s[i] != 8'h0A) b.push_back(s[i]);
    if (b.size() == 0) return -2;
    if (b[0] != 8'h44 && b[0] != 8'h64) return -1;
    if (b.size() < 2 || b.size() > 4) return -1;
    for (int k = 1; k < b.size(); k++) begin
      if (b[k] < 8'h30 || b[k] > 8'h39) return -1;
      v = v * 10 + (b[k] - 8'h30);
    end
    if (v > MAX_DUTY) return -1;
    return v;
  endfunction

  // Registered-read FIFO
  always @(posedge clk) begin
    if (!rst && fifo_rd_en && fifo_q.size() > 0) begin
      fifo_empty   <= (fifo_q.size() == 1);
      fifo_rd_data <= fifo_q.pop_front();
    end
  end

  always @(negedge clk) begin
    int e;
    if (!rst) begin
      cyc++;
      if (duty_valid && cmd_err) chk("pulse_exclusive", 1, 0);
      if (fifo_rd_en && fifo_empty) chk("rd_en_while_empty", 1, 0);
      if (fifo_rd_en) rd_log.push_back(cyc);
      if (duty_valid || cmd_err) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -3;
        chk("outcome", duty_valid ? int'(duty_pct) : -1, e);
        if (duty_valid && e >= 0) model_duty = e;
        if (duty_valid) dv_cnt++;
        if (cmd_err) er_cnt++;
      end
      chk("duty_pct", duty_pct, model_duty);
    end
  end

  task automatic push_bytes(input string s);
    @(negedge clk);
    for (int i = 0; i < s.len(); i++) fifo_q.push_back(s[i]);
    fifo_empty <= 1'b0;
  endtask

  task automatic pulse_eos(input string s);
    int e = model_line(s);
    @(negedge clk);
    fifo_eos = 1'b1;
    if (e != -2) exp_q.push_back(e);
    @(negedge clk);
    fifo_eos = 1'b0;
  endtask

  task automatic send_line(input string s);
    push_bytes(s);
    pulse_eos(s);
  endtask

  task automatic wait_idle(input string name);
    int n = 0, idle = 0;
    while (n < 400 && idle < 4) begin
      @(negedge clk);
      n++;
      if (!busy && fifo_q.size() == 0 && exp_q.size() == 0) idle++;
      else idle = 0;
    end
    chk({name, "_idle"}, idle, 4);
  endtask

  task automatic wait_rd_of(input byte unsigned b, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 200 && !(fifo_rd_en && fifo_q.size() > 0 && fifo_q[0] == b));
    chk({name, "_found"}, (n < 200) ? 1 : 0, 1);
  endtask

  initial begin
    int dv0, er0;
    // Model pinned by hand
    chk("model_D50", model_line("D50\n"), 50);
    chk("model_d100", model_line("d100\r\n"), 100);
    chk("model_D101", model_line("D101\n"), -1);
    chk("model_D0050", model_line("D0050\n"), -1);
    chk("model_X7", model_line("X7\n"), -1);
    chk("model_empty", model_line("\n"), -2);

    repeat (2) @(negedge clk);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_duty", duty_pct, 0);
    chk("rst_pulses", {duty_valid, cmd_err}, 0);
    rst = 1'b0;

    // D50: 4 pops, 3 cycles apart
    rd_log.delete(); dv0 = dv_cnt;
    send_line("D50\n");
    wait_idle("d50");
    chk("d50_rd_cnt", rd_log.size(), 4);
    for (int i = 0; i + 1 < rd_log.size(); i++) chk("d50_rd_gap", rd_log[i+1] - rd_log[i], 3);
    chk("d50_duty", duty_pct, 50);
    chk("d50_dv_cnt", dv_cnt - dv0, 1);

    // CR ignored, overflow and 4-digit rejects
    rd_log.delete();
    send_line("d100\r\n");
    wait_idle("d100");
    chk("d100_duty", duty_pct, 100);
    chk("d100_rd_cnt", rd_log.size(), 6);
    er0 = er_cnt;
    send_line("D101\n");
    wait_idle("d101");
    send_line("D0050\n");
    wait_idle("d0050");
    chk("rej_err_cnt", er_cnt - er0, 2);
    chk("rej_duty", duty_pct, 100);

    // Two queued lines, processed in order
    er0 = er_cnt; dv0 = dv_cnt;
    send_line("X7\n");
    send_line("D7\n");
    wait_idle("x7d7");
    chk("x7d7_duty", duty_pct, 7);
    chk("x7d7_err", er_cnt - er0, 1);
    chk("x7d7_dv", dv_cnt - dv0, 1);

    // eos coincides with PARSE consuming LF
    rd_log.delete();
    push_bytes("D1\n");
    push_bytes("D2\n");
    pulse_eos("D1\n");
    wait_rd_of(8'h0A, "coinc");
    @(negedge clk);
    @(negedge clk);
    fifo_eos = 1'b1;
    exp_q.push_back(2);
    @(negedge clk);
    fifo_eos = 1'b0;
    wait_idle("coinc");
    chk("coinc_duty", duty_pct, 2);
    chk("coinc_rd_cnt", rd_log.size(), 6);

    // Empty line
    rd_log.delete(); dv0 = dv_cnt; er0 = er_cnt;
    send_line("\n");
    wait_idle("empty");
    chk("empty_rd_cnt", rd_log.size(), 1);
    chk("empty_pulses", (dv_cnt - dv0) + (er_cnt - er0), 0);

    // Reset during WAIT of D42
    send_line("D42\n");
    wait_rd_of(8'h44, "rst42");
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_duty", duty_pct, 0);
    chk("mid_rst_pulses", {duty_valid, cmd_err}, 0);
    fifo_q.delete();
    fifo_empty <= 1'b1;
    exp_q.delete();
    model_duty = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // No reading until a fresh eos
    rd_log.delete();
    push_bytes("D9\n");
    repeat (10) @(negedge clk);
    chk("post_rst_no_rd", rd_log.size(), 0);
    chk("post_rst_busy", busy, 0);
    pulse_eos("D9\n");
    wait_idle("d9");
    chk("d9_duty", duty_pct, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
